// File: rtl/mole_round_sequencer_if.sv
// Signal bundle between the whack-a-mole round sequencer and its surroundings:
// game inputs from the board/divider/RNG side, display and status outputs back.
interface mole_round_sequencer_if #(
    parameter int NUM_HOLES = 18
);
    logic                 tick_1hz;
    logic                 speed1;
    logic                 speed2;
    logic                 speed3;
    logic [NUM_HOLES-1:0] switches;
    logic [4:0]           random_pos;
    logic [NUM_HOLES-1:0] target_led;
    logic [7:0]           timer_bcd;
    logic [15:0]          score_bcd;
    logic [1:0]           speed_level;
    logic                 game_over;

    modport master (
        output tick_1hz, speed1, speed2, speed3, switches, random_pos,
        input  target_led, timer_bcd, score_bcd, speed_level, game_over
    );

    modport slave (
        input  tick_1hz, speed1, speed2, speed3, switches, random_pos,
        output target_led, timer_bcd, score_bcd, speed_level, game_over
    );
endinterface

// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round sequencer: spawns moles, scores hits/misses in BCD,
// counts the round down on tick_1hz and holds the result when time runs out.
//
//   state    | meaning
//   S_IDLE   | after reset, waiting for a speed key to start the round
//   S_SPAWN  | one cycle: choose hole, load mole period, LEDs dark
//   S_ACTIVE | mole lit; watch switches for hit/miss, period counting down
//   S_OVER   | round finished; result held until a speed key restarts
module mole_round_sequencer #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int ROUND_SECONDS = 60,
    parameter int NUM_HOLES     = 18
) (
    input logic                   clk,
    input logic                   rst_n,
    mole_round_sequencer_if.slave bus
);
    localparam int              CNT_W      = $clog2(2 * CLK_HZ);
    localparam logic [CNT_W-1:0] LOAD_SLOW = CNT_W'(2 * CLK_HZ - 1);
    localparam logic [CNT_W-1:0] LOAD_MID  = CNT_W'(3 * CLK_HZ / 2 - 1);
    localparam logic [CNT_W-1:0] LOAD_FAST = CNT_W'(CLK_HZ - 1);
    localparam logic [7:0]       TIMER_INIT = {4'(ROUND_SECONDS / 10), 4'(ROUND_SECONDS % 10)};
    localparam logic [5:0]       HOLES      = 6'(NUM_HOLES);

    typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_ACTIVE, S_OVER} state_t;

    state_t               state;
    logic [2:0]           key_s1, key_s2, key_prev, key_fall;
    logic [NUM_HOLES-1:0] sw_s1, sw_s2, sw_prev, toggle;
    logic [NUM_HOLES-1:0] target_q;
    logic [7:0]           timer_q;
    logic [15:0]          score_q;
    logic [1:0]           speed_q;
    logic                 over_q;
    logic [5:0]           prev_hole;
    logic [CNT_W-1:0]     period_cnt;

    logic                 key_any;
    logic [1:0]           key_level;
    logic [5:0]           hole_raw, hole_next;
    logic [CNT_W-1:0]     period_load;
    logic                 hit, miss, tick_last;
    logic [7:0]           timer_next;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return (v == 16'h9999) ? v : r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return (v == 16'h0000) ? v : r;
    endfunction

    // Two-flop synchronizers, then a registered edge/toggle stage. Keys idle
    // high, so their flops reset to 1 to avoid a false press out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1   <= 3'b111;
            key_s2   <= 3'b111;
            key_prev <= 3'b111;
            key_fall <= 3'b000;
            sw_s1    <= '0;
            sw_s2    <= '0;
            sw_prev  <= '0;
            toggle   <= '0;
        end else begin
            key_s1   <= {bus.speed3, bus.speed2, bus.speed1};
            key_s2   <= key_s1;
            key_prev <= key_s2;
            key_fall <= key_prev & ~key_s2;
            sw_s1    <= bus.switches;
            sw_s2    <= sw_s1;
            sw_prev  <= sw_s2;
            toggle   <= sw_s2 ^ sw_prev;
        end
    end

    always_comb begin
        key_any   = |key_fall;
        key_level = key_fall[0] ? 2'd0 : (key_fall[1] ? 2'd1 : 2'd2);
        hole_raw  = ({1'b0, bus.random_pos} < HOLES) ? {1'b0, bus.random_pos}
                                                     : {1'b0, bus.random_pos} - HOLES;
        if (hole_raw != prev_hole) begin
            hole_next = hole_raw;
        end else begin
            hole_next = (hole_raw + 6'd1 == HOLES) ? 6'd0 : hole_raw + 6'd1;
        end
        case (speed_q)
            2'd0:    period_load = LOAD_SLOW;
            2'd1:    period_load = LOAD_MID;
            default: period_load = LOAD_FAST;
        endcase
        hit        = |(toggle & target_q);
        miss       = !hit && |(toggle & ~target_q);
        tick_last  = bus.tick_1hz && (timer_q == 8'h01);
        timer_next = (timer_q[3:0] == 4'd0) ? {timer_q[7:4] - 4'd1, 4'd9}
                                            : {timer_q[7:4], timer_q[3:0] - 4'd1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            target_q   <= '0;
            timer_q    <= TIMER_INIT;
            score_q    <= 16'h0000;
            speed_q    <= 2'd0;
            over_q     <= 1'b0;
            prev_hole  <= 6'd0;
            period_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    target_q <= '0;
                    over_q   <= 1'b0;
                    if (key_any) begin
                        speed_q <= key_level;
                        state   <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    if (key_any) speed_q <= key_level;
                    if (bus.tick_1hz) timer_q <= timer_next;
                    if (tick_last) begin
                        target_q <= '0;
                        over_q   <= 1'b1;
                        state    <= S_OVER;
                    end else begin
                        target_q   <= NUM_HOLES'(1) << hole_next;
                        prev_hole  <= hole_next;
                        period_cnt <= period_load;
                        state      <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (key_any) speed_q <= key_level;
                    if (hit) begin
                        score_q <= bcd_inc(score_q);
                    end else if (miss) begin
                        score_q <= bcd_dec(score_q);
                    end
                    if (period_cnt != '0) period_cnt <= period_cnt - 1'b1;
                    if (bus.tick_1hz) timer_q <= timer_next;
                    // Round end takes priority over respawn; a same-cycle hit still counts.
                    if (tick_last) begin
                        target_q <= '0;
                        over_q   <= 1'b1;
                        state    <= S_OVER;
                    end else if (hit || period_cnt == '0) begin
                        target_q <= '0;
                        state    <= S_SPAWN;
                    end
                end
                S_OVER: begin
                    target_q <= '0;
                    if (key_any) begin
                        score_q <= 16'h0000;
                        timer_q <= TIMER_INIT;
                        speed_q <= key_level;
                        over_q  <= 1'b0;
                        state   <= S_SPAWN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.target_led  = target_q;
    assign bus.timer_bcd   = timer_q;
    assign bus.score_bcd   = score_q;
    assign bus.speed_level = speed_q;
    assign bus.game_over   = over_q;
endmodule

// File: tb/tb_mole_round_sequencer.sv
// Scoreboard bench for mole_round_sequencer: stimulus pushes expected score/timer
// values, a negedge monitor pops them on every output change and checks spawned holes.
module tb_mole_round_sequencer;
    localparam int NH     = 18;
    localparam int CLK_HZ = 20;
    localparam int RS     = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mole_round_sequencer_if #(.NUM_HOLES(NH)) bus ();

    mole_round_sequencer #(
        .CLK_HZ(CLK_HZ),
        .ROUND_SECONDS(RS),
        .NUM_HOLES(NH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] score_exp_q[$];
    logic [7:0]  timer_exp_q[$];

    int mdl_score = 0;
    int mdl_timer = RS;
    int mdl_prev  = 0;
    bit mdl_active = 0;

    int cycle = 0;
    int spawn_cnt = 0;
    int last_spawn_cycle = 0;
    int cur_hole = -1;
    int mon_h;
    bit mon_en = 0;
    bit rp_random = 0;

    logic [15:0]   last_score;
    logic [7:0]    last_timer;
    logic [NH-1:0] last_target;
    logic [4:0]    last_rp;
    logic [NH-1:0] exp_onehot;

    function automatic logic [15:0] to_bcd16(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] to_bcd8(input int v);
        return {4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int pick_hole(input int rp, input int prev);
        int h;
        h = rp % NH;
        if (h == prev) h = (h + 1) % NH;
        return h;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every change on score/timer must match the next queued value;
    // every newly lit mole must be the hole the rules give for the SPAWN-cycle random_pos.
    always @(negedge clk) begin
        cycle++;
        if (mon_en) begin
            if (bus.score_bcd !== last_score) begin
                if (score_exp_q.size() == 0) check("score_unexpected", 32'(bus.score_bcd), 32'(last_score));
                else check("score", 32'(bus.score_bcd), 32'(score_exp_q.pop_front()));
            end
            if (bus.timer_bcd !== last_timer) begin
                if (timer_exp_q.size() == 0) check("timer_unexpected", 32'(bus.timer_bcd), 32'(last_timer));
                else check("timer", 32'(bus.timer_bcd), 32'(timer_exp_q.pop_front()));
            end
            if (bus.target_led !== last_target) begin
                if (last_target == '0) begin
                    mon_h      = pick_hole(int'(last_rp), mdl_prev);
                    exp_onehot = '0;
                    exp_onehot[mon_h] = 1'b1;
                    check("target_hole", 32'(bus.target_led), 32'(exp_onehot));
                    mdl_prev         = mon_h;
                    cur_hole         = mon_h;
                    spawn_cnt++;
                    last_spawn_cycle = cycle;
                end else begin
                    check("target_dark_between", 32'(bus.target_led), 32'(0));
                    cur_hole = -1;
                end
            end
        end
        last_score  = bus.score_bcd;
        last_timer  = bus.timer_bcd;
        last_target = bus.target_led;
        last_rp     = bus.random_pos;
    end

    always @(posedge clk) begin
        #1;
        if (rp_random) bus.random_pos = 5'($urandom_range(0, 31));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_spawn(output int t);
        int s;
        int k;
        s = spawn_cnt;
        k = 0;
        while (spawn_cnt == s && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (spawn_cnt == s) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spawn_timeout: no new mole within %0d cycles", k);
        end
        t = last_spawn_cycle;
    endtask

    task automatic press(input int n);
        case (n)
            1:       bus.speed1 = 1'b0;
            2:       bus.speed2 = 1'b0;
            default: bus.speed3 = 1'b0;
        endcase
        if (!mdl_active) begin
            if (mdl_score != 0) score_exp_q.push_back(16'h0000);
            if (mdl_timer != RS) timer_exp_q.push_back(to_bcd8(RS));
            mdl_score  = 0;
            mdl_timer  = RS;
            mdl_active = 1;
        end
        repeat (3) step();
        bus.speed1 = 1'b1;
        bus.speed2 = 1'b1;
        bus.speed3 = 1'b1;
    endtask

    task automatic model_hit();
        if (mdl_score < 9999) begin
            mdl_score++;
            score_exp_q.push_back(to_bcd16(mdl_score));
        end
    endtask

    task automatic model_miss();
        if (mdl_score > 0) begin
            mdl_score--;
            score_exp_q.push_back(to_bcd16(mdl_score));
        end
    endtask

    // kind: 0 hit, 1 miss, 2 hit plus a simultaneous non-target toggle
    task automatic act(input int kind);
        int o;
        int h;
        h = (cur_hole < 0) ? 0 : cur_hole;
        o = (h + 1 + int'($urandom_range(0, NH - 2))) % NH;
        if (kind != 1) bus.switches[h] = ~bus.switches[h];
        if (kind != 0) bus.switches[o] = ~bus.switches[o];
        if (kind == 1) model_miss();
        else model_hit();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, lat, h, n_hits;
        logic [15:0] old_score;
        logic [4:0]  rfix;

        bus.tick_1hz   = 1'b0;
        bus.speed1     = 1'b1;
        bus.speed2     = 1'b1;
        bus.speed3     = 1'b1;
        bus.switches   = '0;
        bus.random_pos = 5'd20;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        step();
        mon_en = 1;

        check("reset_target", 32'(bus.target_led), 32'(0));
        check("reset_timer", 32'(bus.timer_bcd), 32'h03);
        check("reset_score", 32'(bus.score_bcd), 32'h0000);
        check("reset_over", 32'(bus.game_over), 32'(0));
        check("reset_speed", 32'(bus.speed_level), 32'(0));

        press(2);
        wait_spawn(t0);
        check("speed2_level", 32'(bus.speed_level), 32'(1));
        check("first_target_bit2", 32'(bus.target_led), 32'h4);

        old_score = bus.score_bcd;
        bus.switches[2] = ~bus.switches[2];
        model_hit();
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.score_bcd !== old_score) begin
                lat = i;
                break;
            end
        end
        check("hit_latency", 32'(lat), 32'(4));
        wait_spawn(t0);
        check("new_hole_not_2", 32'(bus.target_led[2]), 32'(0));

        act(1);
        wait_spawn(t0);
        act(1);
        repeat (6) step();
        check("miss_at_zero", 32'(bus.score_bcd), 32'h0000);
        wait_spawn(t0);
        act(0);
        wait_spawn(t0);
        act(1);
        wait_spawn(t0);
        act(2);
        repeat (6) step();
        check("hit_and_miss", 32'(bus.score_bcd), 32'h0001);

        rp_random = 1;
        repeat (30) begin
            wait_spawn(t0);
            act(int'($urandom_range(0, 2)));
        end

        wait_spawn(t0);
        press(3);
        wait_spawn(t1);
        wait_spawn(t2);
        wait_spawn(t3);
        check("old_period_kept", 32'(t1 - t0), 32'(31));
        check("fast_period_1", 32'(t2 - t1), 32'(21));
        check("fast_period_2", 32'(t3 - t2), 32'(21));
        check("speed3_level", 32'(bus.speed_level), 32'(2));

        for (int i = 0; i < 3; i++) begin
            wait_spawn(t0);
            timer_exp_q.push_back(to_bcd8(mdl_timer - 1));
            mdl_timer--;
            if (mdl_timer == 0) mdl_active = 0;
            bus.tick_1hz = 1'b1;
            step();
            bus.tick_1hz = 1'b0;
        end
        step();
        step();
        check("over_flag", 32'(bus.game_over), 32'(1));
        check("over_target", 32'(bus.target_led), 32'(0));
        check("over_timer", 32'(bus.timer_bcd), 32'h00);

        for (int i = 0; i < 4; i++) begin
            bus.tick_1hz = 1'b1;
            bus.switches[$urandom_range(0, NH - 1)] ^= 1'b1;
            step();
            bus.tick_1hz = 1'b0;
            repeat (3) step();
        end
        repeat (8) step();
        check("over_score_held", 32'(bus.score_bcd), 32'(to_bcd16(mdl_score)));
        check("over_timer_held", 32'(bus.timer_bcd), 32'h00);
        check("over_flag_held", 32'(bus.game_over), 32'(1));

        press(1);
        wait_spawn(t0);
        check("restart_speed", 32'(bus.speed_level), 32'(0));
        check("restart_over", 32'(bus.game_over), 32'(0));
        check("restart_timer", 32'(bus.timer_bcd), 32'h03);
        check("restart_score", 32'(bus.score_bcd), 32'h0000);

        // Back-to-back hits: with random_pos fixed the holes alternate, so a
        // toggle every two cycles lands in each mole's first ACTIVE cycle.
        rp_random = 0;
        rfix = 5'($urandom_range(0, 31));
        step();
        bus.random_pos = rfix;
        wait_spawn(t0);
        wait_spawn(t0);
        h = cur_hole;
        n_hits = 9999 - mdl_score + 2;
        for (int i = 0; i < n_hits; i++) begin
            bus.switches[h] = ~bus.switches[h];
            model_hit();
            h = pick_hole(int'(rfix), h);
            step();
            step();
        end
        repeat (10) step();
        check("score_saturated", 32'(bus.score_bcd), 32'h9999);

        check("score_queue_drained", 32'(score_exp_q.size()), 32'(0));
        check("timer_queue_drained", 32'(timer_exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mole_round_sequencer.md
# mole_round_sequencer

Round sequencer for the whack-a-mole game. It runs one timed round: start on a speed-key press, spawn moles from the random hole index at the selected period, and detect hits and misses from switch toggles. It keeps the BCD score and countdown, and holds the final result when the round ends. It sits between the clock divider and random generator on one side and the LED and seven-segment decoders on the other; its BCD outputs drive the decoders digit by digit, with no divide or modulo.

## Interface
- CLK_HZ, 50_000_000, clk cycles per second; mole periods derive from it (benches use 20).
- ROUND_SECONDS, 60, round length in seconds, 1..99.
- NUM_HOLES, 18, number of holes/LEDs/switches.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_1hz  in  1  single-cycle pulse once per second, synchronous to clk.
- speed1, speed2, speed3  in  1 each  active-low keys, debounced but asynchronous; 2-flop synchronized internally.
- switches  in  NUM_HOLES  player switches, asynchronous; 2-flop synchronized internally.
- random_pos  in  5  free-running random hole index, 0..31.
- target_led  out  NUM_HOLES  one-hot lit mole, or 0.
- timer_bcd  out  8  remaining seconds as two BCD digits.
- score_bcd  out  16  score as four BCD digits, 0000..9999.
- speed_level  out  2  0/1/2 for 2 s / 1.5 s / 1 s mole period.
- game_over  out  1  high in OVER.

## Operation
States and transitions:
- IDLE:
  - target_led=0, score 0, timer=ROUND_SECONDS.
  - A synchronized falling edge on speedN sets speed_level=N-1, then goes to SPAWN.
  - Simultaneous edges: the lowest N wins.
- SPAWN (1 cycle):
  - hole = random_pos if < NUM_HOLES, else random_pos-NUM_HOLES.
  - If hole equals the previous hole, use (hole+1) mod NUM_HOLES.
  - target_led = 1<<hole.
  - Load the period counter with 2·CLK_HZ-1, 3·CLK_HZ/2-1 or CLK_HZ-1 by speed_level.
  - Go to ACTIVE.
- ACTIVE:
  - toggle = sync_switches ^ prev_sync_switches.
  - Hit = toggle & target_led nonzero: score +1 (BCD carry, saturates at 9999), go to SPAWN.
  - Miss = toggle outside the target with no hit that cycle: score −1 (saturates at 0000), stay in ACTIVE.
  - Hit and miss in the same cycle: hit only.
  - Period counter reaching 0 with no hit: go to SPAWN, no penalty.
- Countdown:
  - tick_1hz in SPAWN or ACTIVE decrements timer_bcd in BCD (10→09).
  - Decrement from 01 to 00 goes to OVER the next cycle.
  - A hit in that same cycle is still scored.
- Speed changes mid-round: a speedN edge in SPAWN or ACTIVE updates speed_level; the new period applies at the next SPAWN load only.
- OVER:
  - target_led=0, game_over=1, score and timer (00) held.
  - A speedN edge clears the score, reloads the timer, sets speed_level and goes to SPAWN.
- Reset (asynchronous, any state, including mid-round): IDLE, target_led=0, timer_bcd=ROUND_SECONDS in BCD, score_bcd=0000, speed_level=0, game_over=0, previous hole=0.
- Synchronizer and previous-value registers reset to 1 for keys and 0 for switches, so reset itself produces no false edge or toggle.

## Timing
- Input latency: async pin → sync 2 cycles → edge/toggle detect 1 cycle → state and score update on the following edge.
- Switch change to score change: 4 clk cycles.
- Hit to new target_led: 2 cycles (ACTIVE→SPAWN→ACTIVE); target_led is 0 during SPAWN.
- Mole lifetime with no hit: exactly period+1 cycles, counted from the SPAWN cycle.
- tick_1hz to timer change: 1 cycle. tick_1hz is ignored in IDLE and OVER.
- All outputs are registered; no combinational input-to-output path.

## Test plan
All scenarios use CLK_HZ=20, ROUND_SECONDS=3.
- Reset → target_led=0, timer_bcd=8'h03, score_bcd=0, game_over=0. Pulse speed2 low → speed_level=1 and a one-hot target appears.
- random_pos=20 at SPAWN → target_led bit 2. Toggle switch 2 → score 0001 four cycles later, then a new hole ≠2.
- Toggle a non-target switch at score 0000 → score stays 0000. A hit then a miss → 0001 then 0000.
- Toggle the target switch and another switch in the same cycle → score +1 only.
- No input at speed_level 2 → target changes every 21 cycles. speed3 pressed mid-mole → the current mole keeps the old period.
- Three tick_1hz pulses → 02, 01, 00 → game_over=1, target_led=0. Further ticks and toggles change nothing. A speed1 press restarts with score 0000 and timer 03.
- Score preset near saturation via a long hit run: at 9999 a further hit keeps 9999. Carry case: 0099+1=0100.
